mem_intv_delay_buffer: RTL and testbench
========================================

MEM_INTV_DELAY_BUFFER -- requirements
Module: mem_intv_delay_buffer

Interface
REQ-001 Parameter p_num_chan, default 2: number of independent val/rdy channels, 1..8.
REQ-002 Parameter p_msg_bits, default 32: payload bits per channel, excluding opaque field.
REQ-003 Parameter p_opaq_bits, default 8: opaque tag bits per channel, passed through unmodified.
REQ-004 Parameter p_depth, default 4: per-channel FIFO entries, power of two, 2..32.
REQ-005 Parameter p_intv_bits, default 4: width of each channel's interval configuration field.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 cfg_bypass  in  1  1 = ignore interval spacing on all channels.
REQ-009 cfg_intv  in  p_num_chan*p_intv_bits  minimum cycles between output transfers, per channel; channel i occupies bits [i*p_intv_bits +: p_intv_bits].
REQ-010 in_val / in_rdy  in / out  p_num_chan each  per-channel input handshake.
REQ-011 in_msg  in  p_num_chan*(p_opaq_bits+p_msg_bits)  per-channel input; opaque field in the MSBs of each slice.
REQ-012 out_val / out_rdy  out / in  p_num_chan each  per-channel output handshake.
REQ-013 out_msg  out  p_num_chan*(p_opaq_bits+p_msg_bits)  per-channel output, same slice layout as in_msg.
REQ-014 xfer_cnt  out  p_num_chan*16  per-channel count of completed output transfers.

Function
REQ-015 Transfer occurs on a channel in a cycle where val and rdy are both high at the rising edge.
REQ-016 Channels are fully independent; no channel's state affects another's handshake or data.
REQ-017 Each channel buffers messages in a FIFO of p_depth entries; output order equals input order per channel.
REQ-018 in_rdy[i] = 1 exactly when FIFO i holds fewer than p_depth entries; it does not depend on out_rdy (no combinational in/out path).
REQ-019 A message enqueued in cycle t is presentable on out_msg no earlier than cycle t+1; no same-cycle fall-through.
REQ-020 Simultaneous enqueue and dequeue on a non-full, non-empty FIFO leaves occupancy unchanged.
REQ-021 A FIFO at full occupancy with a dequeue in the same cycle still deasserts in_rdy that cycle.
REQ-022 Read and write pointers wrap modulo p_depth; occupancy is tracked with one extra bit to distinguish full from empty.
REQ-023 Each channel has an interval down-counter of p_intv_bits bits.
REQ-024 On an output transfer on channel i, its counter loads max(cfg_intv[i],1)-1; otherwise it decrements when nonzero.
REQ-025 out_val[i] = FIFO i non-empty AND (counter i == 0 OR cfg_bypass == 1).
REQ-026 cfg_intv of 0 or 1 permits back-to-back output transfers; value N permits transfers no closer than N cycles apart.
REQ-027 cfg_intv is sampled only at the moment of a transfer; changing it mid-countdown does not alter the running count.
REQ-028 Asserting cfg_bypass releases a held message in the same cycle; the counter keeps counting and is reloaded on transfers.
REQ-029 out_msg[i] shows the FIFO head entry whenever out_val[i] = 1; while out_val[i] = 0 it shows the head storage slot, which is never X after reset.
REQ-030 xfer_cnt[i] increments by 1 per output transfer and saturates at 16'hFFFF.
REQ-031 Once out_val[i] is asserted, it and out_msg[i] stay stable until the transfer completes.

Reset
REQ-032 While rst_n = 0, all channels return immediately to the reset state, independent of clk.
REQ-033 Reset state: FIFOs empty, pointers 0, counters 0, storage 0, xfer_cnt 0.
REQ-034 Reset outputs: out_val = 0, in_rdy = all ones, out_msg = 0.
REQ-035 Assertion mid-operation discards all buffered messages; no output transfer occurs in the reset cycle.
REQ-036 After rst_n deasserts, the first edge accepts input normally.

Verification
REQ-037 Single message: cfg_intv=0, in_msg[0]=0xA5_DEADBEEF at t -> out_val[0]=1 at t+1 with the same data; xfer_cnt[0]=1 after out_rdy.
REQ-038 Spacing: cfg_intv[0]=3, 4 messages queued, out_rdy=1 -> transfers at t, t+3, t+6, t+9; order preserved.
REQ-039 Full: p_depth=4, out_rdy=0, 5 inputs offered -> in_rdy=0 after 4 accepted; 5th held; one dequeue -> in_rdy=1 next cycle.
REQ-040 Bypass: cfg_intv=15, mid-countdown cfg_bypass=1 -> out_val rises in the same cycle; back-to-back drain.
REQ-041 Independence: ch0 stalled with out_rdy=0 and full while ch1 streams at intv=2 -> ch1 throughput unaffected, one transfer every 2 cycles.
REQ-042 Async reset: rst_n=0 between edges with 3 entries buffered -> out_val=0, in_rdy=1 before the next edge; xfer_cnt=0.

Source files
------------

// File: rtl/mem_intv_delay_buffer_if.sv
// Per-channel val/rdy handshake bundle for the interval delay buffer.
// The master side feeds input messages and accepts output messages.
interface mem_intv_delay_buffer_if #(
  parameter int unsigned p_num_chan  = 2,
  parameter int unsigned p_msg_bits  = 32,
  parameter int unsigned p_opaq_bits = 8
);
  localparam int unsigned MW = p_opaq_bits + p_msg_bits;

  logic [p_num_chan-1:0]    in_val;
  logic [p_num_chan-1:0]    in_rdy;
  logic [p_num_chan*MW-1:0] in_msg;
  logic [p_num_chan-1:0]    out_val;
  logic [p_num_chan-1:0]    out_rdy;
  logic [p_num_chan*MW-1:0] out_msg;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg
  );
endinterface

// File: rtl/mem_intv_delay_buffer.sv
// Multi-channel FIFO buffer that enforces a configurable minimum spacing
// between output transfers on each channel, with a global spacing bypass.
module mem_intv_delay_buffer #(
  parameter int unsigned p_num_chan  = 2,
  parameter int unsigned p_msg_bits  = 32,
  parameter int unsigned p_opaq_bits = 8,
  parameter int unsigned p_depth     = 4,
  parameter int unsigned p_intv_bits = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_bypass,
  input  logic [p_num_chan*p_intv_bits-1:0] cfg_intv,
  output logic [p_num_chan*16-1:0]          xfer_cnt,
  mem_intv_delay_buffer_if.slave            bus
);
  localparam int unsigned MW   = p_opaq_bits + p_msg_bits;
  localparam int unsigned PW   = $clog2(p_depth);
  localparam int unsigned PTRW = PW + 1;
  localparam int unsigned IB   = p_intv_bits;

  for (genvar i = 0; i < p_num_chan; i++) begin : g_chan
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [MW-1:0]   r_mem [p_depth];
    logic [IB-1:0]   r_intv_cnt;
    logic [15:0]     r_xfer;

    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_deq;
    logic            w_out_val;
    logic [IB-1:0]   w_intv;
    logic [IB-1:0]   w_reload;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty.
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_out_val = !w_empty && ((r_intv_cnt == '0) || cfg_bypass);
    assign w_enq     = bus.in_val[i] && !w_full;
    assign w_deq     = w_out_val && bus.out_rdy[i];
    assign w_intv    = cfg_intv[i*IB +: IB];
    assign w_reload  = (w_intv == '0) ? '0 : w_intv - IB'(1);

    assign bus.in_rdy[i]           = !w_full;
    assign bus.out_val[i]          = w_out_val;
    assign bus.out_msg[i*MW +: MW] = r_mem[r_rd_ptr[PW-1:0]];
    assign xfer_cnt[i*16 +: 16]    = r_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        for (int k = 0; k < p_depth; k++) r_mem[k] <= '0;
      end else begin
        if (w_enq) begin
          r_mem[r_wr_ptr[PW-1:0]] <= bus.in_msg[i*MW +: MW];
          r_wr_ptr                <= r_wr_ptr + PTRW'(1);
        end
        if (w_deq) r_rd_ptr <= r_rd_ptr + PTRW'(1);
      end
    end

    // Interval is sampled only on a transfer; the running count ignores later cfg changes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_intv_cnt <= '0;
        r_xfer     <= '0;
      end else begin
        if (w_deq) begin
          r_intv_cnt <= w_reload;
        end else if (r_intv_cnt != '0) begin
          r_intv_cnt <= r_intv_cnt - IB'(1);
        end
        if (w_deq && (r_xfer != 16'hFFFF)) r_xfer <= r_xfer + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_intv_delay_buffer.sv
// Scoreboard bench: a negedge monitor models each channel as a queue plus
// "cycles since last transfer" and checks handshakes, data and counters.
module tb_mem_intv_delay_buffer;
  localparam int unsigned NCH   = 2;
  localparam int unsigned MSGB  = 32;
  localparam int unsigned OPQB  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IB    = 4;
  localparam int unsigned MW    = MSGB + OPQB;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_bypass = 1'b0;
  logic [NCH*IB-1:0]   cfg_intv = '0;
  logic [NCH*16-1:0]   xfer_cnt;

  mem_intv_delay_buffer_if #(.p_num_chan(NCH), .p_msg_bits(MSGB), .p_opaq_bits(OPQB)) bus ();

  mem_intv_delay_buffer #(
    .p_num_chan(NCH), .p_msg_bits(MSGB), .p_opaq_bits(OPQB),
    .p_depth(DEPTH), .p_intv_bits(IB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_bypass(cfg_bypass),
    .cfg_intv(cfg_intv), .xfer_cnt(xfer_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int ch, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %h expected %h at %0t", nm, ch, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [MW-1:0] q [NCH][$];
  longint        last_xfer [NCH];
  longint        need_gap  [NCH];
  int unsigned   mcnt      [NCH];
  longint        cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        q[c].delete();
        last_xfer[c] = -1000;
        need_gap[c]  = 1;
        mcnt[c]      = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        int   occ;
        logic exp_rdy, exp_ov, enq, deq;
        int   n;
        occ     = q[c].size();
        exp_rdy = occ < DEPTH;
        exp_ov  = (occ > 0) && (cfg_bypass || ((cyc - last_xfer[c]) >= need_gap[c]));
        check("in_rdy",   c, 64'(bus.in_rdy[c]),  64'(exp_rdy));
        check("out_val",  c, 64'(bus.out_val[c]), 64'(exp_ov));
        check("xfer_cnt", c, 64'(xfer_cnt[c*16 +: 16]), 64'(mcnt[c]));
        if (exp_ov) check("out_msg", c, 64'(bus.out_msg[c*MW +: MW]), 64'(q[c][0]));
        enq = bus.in_val[c] && exp_rdy;
        deq = exp_ov && bus.out_rdy[c];
        if (deq) begin
          void'(q[c].pop_front());
          n = int'(cfg_intv[c*IB +: IB]);
          need_gap[c]  = (n < 1) ? 1 : n;
          last_xfer[c] = cyc;
          if (mcnt[c] < 32'hFFFF) mcnt[c]++;
        end
        if (enq) q[c].push_back(bus.in_msg[c*MW +: MW]);
      end
      cyc++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [MW-1:0] rnd_msg();
    return MW'({$urandom, $urandom});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_val  = '0;
    bus.in_msg  = '0;
    bus.out_rdy = '0;
    #3;
    check("rst_out_val",  0, 64'(bus.out_val), 64'(0));
    check("rst_in_rdy",   0, 64'(bus.in_rdy),  64'(2'b11));
    check("rst_out_msg",  0, 64'(bus.out_msg[MW-1:0]), 64'(0));
    check("rst_xfer_cnt", 0, 64'(xfer_cnt), 64'(0));
    tick;
    rst_n = 1'b1;
    tick;

    // Single message with zero interval
    bus.out_rdy = 2'b11;
    bus.in_val[0] = 1'b1;
    bus.in_msg[0 +: MW] = 40'hA5_DEADBEEF;
    tick;
    bus.in_val[0] = 1'b0;
    check("single_val", 0, 64'(bus.out_val[0]), 64'(1));
    check("single_msg", 0, 64'(bus.out_msg[0 +: MW]), 64'h00A5_DEADBEEF);
    tick;
    check("single_cnt", 0, 64'(xfer_cnt[15:0]), 64'(1));

    // Spacing of 3 with four queued messages
    bus.out_rdy = 2'b00;
    cfg_intv[0 +: IB] = 4'd3;
    for (int k = 0; k < 4; k++) begin
      bus.in_val[0] = 1'b1;
      bus.in_msg[0 +: MW] = rnd_msg();
      tick;
    end
    bus.in_val[0] = 1'b0;
    bus.out_rdy[0] = 1'b1;
    repeat (14) tick;

    // Full: five offered with output stalled
    bus.out_rdy = 2'b00;
    cfg_intv[0 +: IB] = 4'd0;
    bus.in_val[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_msg[0 +: MW] = rnd_msg();
      tick;
    end
    check("full_in_rdy", 0, 64'(bus.in_rdy[0]), 64'(0));
    bus.in_msg[0 +: MW] = rnd_msg();
    bus.out_rdy[0] = 1'b1;
    tick;
    bus.out_rdy[0] = 1'b0;
    #1;
    check("full_reopen", 0, 64'(bus.in_rdy[0]), 64'(1));
    tick;
    bus.in_val[0] = 1'b0;

    // Drain, then bypass releasing mid-countdown
    bus.out_rdy[0] = 1'b1;
    repeat (6) tick;
    bus.out_rdy[0] = 1'b0;
    cfg_intv[0 +: IB] = 4'd15;
    bus.in_val[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_msg[0 +: MW] = rnd_msg();
      tick;
    end
    bus.in_val[0] = 1'b0;
    bus.out_rdy[0] = 1'b1;
    repeat (5) tick;
    check("bypass_held", 0, 64'(bus.out_val[0]), 64'(0));
    cfg_bypass = 1'b1;
    #1;
    check("bypass_rise", 0, 64'(bus.out_val[0]), 64'(1));
    repeat (5) tick;
    cfg_bypass = 1'b0;
    cfg_intv = '0;
    repeat (16) tick;

    // Independence: ch0 full and stalled, ch1 streaming at interval 2
    bus.out_rdy = 2'b10;
    cfg_intv[IB +: IB] = 4'd2;
    bus.in_val = 2'b11;
    for (int k = 0; k < 30; k++) begin
      bus.in_msg[0 +: MW]  = rnd_msg();
      bus.in_msg[MW +: MW] = rnd_msg();
      tick;
    end
    bus.in_val = 2'b00;
    bus.out_rdy = 2'b11;
    repeat (12) tick;

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      if ((k % 64) == 0) cfg_intv = (NCH*IB)'($urandom);
      cfg_bypass = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < NCH; c++) begin
        bus.in_val[c]  = ($urandom_range(0, 2) != 0);
        bus.out_rdy[c] = ($urandom_range(0, 3) != 0);
        bus.in_msg[c*MW +: MW] = rnd_msg();
      end
      tick;
    end

    // Async reset with three entries buffered
    bus.in_val = '0;
    bus.out_rdy = '0;
    cfg_bypass = 1'b0;
    cfg_intv = '0;
    tick;
    bus.in_val[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_msg[0 +: MW] = rnd_msg();
      tick;
    end
    bus.in_val[0] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_val", 0, 64'(bus.out_val), 64'(0));
    check("arst_in_rdy",  0, 64'(bus.in_rdy),  64'(2'b11));
    check("arst_xfer",    0, 64'(xfer_cnt), 64'(0));
    check("arst_out_msg", 0, 64'(bus.out_msg[MW-1:0]), 64'(0));
    tick;
    rst_n = 1'b1;

    // Traffic after reset, then drain
    bus.out_rdy = 2'b11;
    bus.in_val = 2'b11;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < NCH; c++) bus.in_msg[c*MW +: MW] = rnd_msg();
      tick;
    end
    bus.in_val = '0;
    cfg_bypass = 1'b1;
    repeat (12) tick;
    check("drain_out_val", 0, 64'(bus.out_val), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
